// File: rtl/mcpu_ctrl_fsm_pkg.sv
// Shared multi-cycle MIPS controller definitions: state codes, ALU ops, opcode/funct constants.
// Latency: n/a (package only).
// Backpressure: n/a.
package mcpu_defs;

    typedef enum logic [4:0] {
        S_IF   = 5'd0,  S_ID   = 5'd1,  S_MADR = 5'd2,  S_MRD  = 5'd3,
        S_LWB  = 5'd4,  S_MWR  = 5'd5,  S_REXE = 5'd6,  S_RWB  = 5'd7,
        S_BEQ  = 5'd8,  S_BNE  = 5'd9,  S_J    = 5'd10, S_JAL  = 5'd11,
        S_IEXE = 5'd12, S_IWB  = 5'd13, S_LUI  = 5'd14, S_JR   = 5'd15,
        S_JALR = 5'd16
    } state_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011,
        ALU_NOR = 3'b100, ALU_SRL = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [5:0] FUN_ADD  = 6'b100000;
    localparam logic [5:0] FUN_SUB  = 6'b100010;
    localparam logic [5:0] FUN_AND  = 6'b100100;
    localparam logic [5:0] FUN_OR   = 6'b100101;
    localparam logic [5:0] FUN_XOR  = 6'b100110;
    localparam logic [5:0] FUN_NOR  = 6'b100111;
    localparam logic [5:0] FUN_SRL  = 6'b000010;
    localparam logic [5:0] FUN_SLT  = 6'b101010;
    localparam logic [5:0] FUN_JR   = 6'b001000;
    localparam logic [5:0] FUN_JALR = 6'b001001;

endpackage

// File: rtl/mcpu_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle: instruction fields, memory handshake, datapath controls.
// Latency: n/a (wires only).
// Backpressure: MIO_ready from memory stalls the controller in fetch/load/store states.
interface mcpu_ctrl_fsm_if;
    logic [5:0] OPcode;
    logic [5:0] Fun;
    logic       MIO_ready;
    logic       zero;
    logic       MemRead;
    logic       MemWrite;
    logic       CPU_MIO;
    logic       IorD;
    logic       IRWrite;
    logic [1:0] RegDst;
    logic [1:0] DatatoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       PCWrite;
    logic [2:0] ALU_Control;
    logic [4:0] state_out;

    modport master (
        input  OPcode, Fun, MIO_ready, zero,
        output MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegDst, DatatoReg,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, PCWrite, ALU_Control, state_out
    );

    modport slave (
        output OPcode, Fun, MIO_ready, zero,
        input  MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegDst, DatatoReg,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, PCWrite, ALU_Control, state_out
    );
endinterface

// File: rtl/mcpu_alu_dec.sv
// ALU operation decode from funct (R-type) or opcode (immediate ALU ops).
// Latency: combinational.
// Backpressure: none.
module mcpu_alu_dec
    import mcpu_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] fun,
    output alu_op_t    alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            case (fun)
                FUN_ADD: alu_op = ALU_ADD;
                FUN_SUB: alu_op = ALU_SUB;
                FUN_AND: alu_op = ALU_AND;
                FUN_OR:  alu_op = ALU_OR;
                FUN_XOR: alu_op = ALU_XOR;
                FUN_NOR: alu_op = ALU_NOR;
                FUN_SRL: alu_op = ALU_SRL;
                FUN_SLT: alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end else begin
            case (opcode)
                OP_ADDI: alu_op = ALU_ADD;
                OP_SLTI: alu_op = ALU_SLT;
                OP_ANDI: alu_op = ALU_AND;
                OP_ORI:  alu_op = ALU_OR;
                OP_XORI: alu_op = ALU_XOR;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS control unit: one state register, Moore outputs plus same-cycle branch resolve.
// Latency: 3-5 cycles per instruction; fetch/load/store hold one extra cycle per MIO_ready=0.
// Backpressure: MIO_ready=0 holds IF/MRD/MWR with outputs stable.
module mcpu_ctrl_fsm
    import mcpu_defs::*;
(
    input  logic          clk,
    input  logic          reset,
    mcpu_ctrl_fsm_if.master bus
);

    state_t  state;
    state_t  state_nxt;
    alu_op_t dec_alu;

    mcpu_alu_dec u_alu_dec (
        .opcode (bus.OPcode),
        .fun    (bus.Fun),
        .alu_op (dec_alu)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IF;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt       = S_IF;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IorD        = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegDst      = 2'b00;
        bus.DatatoReg   = 2'b00;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.PCSource    = 2'b00;
        bus.PCWrite     = 1'b0;
        bus.ALU_Control = ALU_ADD;

        case (state)
            S_IF: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.MIO_ready;
                bus.PCWrite = bus.MIO_ready;
                state_nxt   = bus.MIO_ready ? S_ID : S_IF;
            end
            S_ID: begin
                bus.ALUSrcB = 2'b11;
                case (bus.OPcode)
                    OP_RTYPE: begin
                        if (bus.Fun == FUN_JR)        state_nxt = S_JR;
                        else if (bus.Fun == FUN_JALR) state_nxt = S_JALR;
                        else                          state_nxt = S_REXE;
                    end
                    OP_LW, OP_SW: state_nxt = S_MADR;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_BNE:       state_nxt = S_BNE;
                    OP_J:         state_nxt = S_J;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_LUI:       state_nxt = S_LUI;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_nxt = S_IEXE;
                    default:      state_nxt = S_IF;
                endcase
            end
            S_MADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_nxt   = (bus.OPcode == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                state_nxt   = bus.MIO_ready ? S_LWB : S_MRD;
            end
            S_LWB: begin
                bus.DatatoReg = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            S_MWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                state_nxt    = bus.MIO_ready ? S_IF : S_MWR;
            end
            S_REXE, S_IEXE: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUSrcB     = (state == S_IEXE) ? 2'b10 : 2'b00;
                bus.ALU_Control = dec_alu;
                state_nxt       = (state == S_IEXE) ? S_IWB : S_RWB;
            end
            S_RWB: begin
                bus.RegDst   = 2'b01;
                bus.RegWrite = 1'b1;
            end
            S_IWB: bus.RegWrite = 1'b1;
            // Branch taken/not-taken resolves here on the live zero flag.
            S_BEQ, S_BNE: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALU_Control = ALU_SUB;
                bus.PCSource    = 2'b01;
                bus.PCWrite     = (state == S_BEQ) ? bus.zero : ~bus.zero;
            end
            S_J, S_JAL: begin
                bus.PCSource = 2'b10;
                bus.PCWrite  = 1'b1;
                if (state == S_JAL) begin
                    bus.RegDst    = 2'b10;
                    bus.DatatoReg = 2'b11;
                    bus.RegWrite  = 1'b1;
                end
            end
            S_JR, S_JALR: begin
                bus.PCSource = 2'b11;
                bus.PCWrite  = 1'b1;
                if (state == S_JALR) begin
                    bus.RegDst    = 2'b01;
                    bus.DatatoReg = 2'b11;
                    bus.RegWrite  = 1'b1;
                end
            end
            S_LUI: begin
                bus.DatatoReg = 2'b10;
                bus.RegWrite  = 1'b1;
            end
            default: state_nxt = S_IF;
        endcase

        // Reset kills every architectural write in the cycle it is asserted.
        if (reset) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.RegWrite = 1'b0;
            bus.MemWrite = 1'b0;
            bus.MemRead  = 1'b0;
        end
        bus.CPU_MIO   = bus.MemRead | bus.MemWrite;
        bus.state_out = state;
    end

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Bench for mcpu_ctrl_fsm: per-instruction vector table plus hand sequences for stalls and reset.
module tb_mcpu_ctrl_fsm;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mcpu_ctrl_fsm_if bus ();

    mcpu_ctrl_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // write-enable pattern {MemRead, MemWrite, IRWrite, RegWrite, PCWrite}
    localparam logic [4:0] W_0    = 5'b00000;
    localparam logic [4:0] W_IF   = 5'b10101;
    localparam logic [4:0] W_MR   = 5'b10000;
    localparam logic [4:0] W_MW   = 5'b01000;
    localparam logic [4:0] W_RW   = 5'b00010;
    localparam logic [4:0] W_PC   = 5'b00001;
    localparam logic [4:0] W_LINK = 5'b00011;

    // datapath pattern {RegDst, DatatoReg, ALUSrcA, ALUSrcB, PCSource, IorD}
    localparam logic [9:0] SG_IF   = 10'b00_00_0_01_00_0;
    localparam logic [9:0] SG_ID   = 10'b00_00_0_11_00_0;
    localparam logic [9:0] SG_RWB  = 10'b01_00_0_00_00_0;
    localparam logic [9:0] SG_IWB  = 10'b00_00_0_00_00_0;
    localparam logic [9:0] SG_LWB  = 10'b00_01_0_00_00_0;
    localparam logic [9:0] SG_MEM  = 10'b00_00_0_00_00_1;
    localparam logic [9:0] SG_BR   = 10'b00_00_1_00_01_0;
    localparam logic [9:0] SG_J    = 10'b00_00_0_00_10_0;
    localparam logic [9:0] SG_JAL  = 10'b10_11_0_00_10_0;
    localparam logic [9:0] SG_JR   = 10'b00_00_0_00_11_0;
    localparam logic [9:0] SG_JALR = 10'b01_11_0_00_11_0;
    localparam logic [9:0] SG_LUI  = 10'b00_10_0_00_00_0;

    typedef struct {
        logic [5:0]      op;
        logic [5:0]      fun;
        logic            z;
        int              n;
        logic [0:5][4:0] st;
        logic [0:5][4:0] we;
        logic [2:0]      alu;
        logic [9:0]      sig;
    } vec_t;

    typedef struct {
        logic [4:0] st;
        logic [4:0] we;
        bit         chk_alu;
        logic [2:0] alu;
        bit         chk_sig;
        logic [9:0] sig;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // One clock: drive inputs, queue the expectation, compare at the falling edge.
    task automatic step(input bit rst, input bit mio, input logic [4:0] st, input logic [4:0] we,
                        input bit ca, input logic [2:0] alu, input bit cs, input logic [9:0] sig);
        exp_t e;
        exp_t g;
        reset         = rst;
        bus.MIO_ready = mio;
        e = '{st, we, ca, alu, cs, sig};
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty cyc=%0d got=0 want=1", cyc);
        end else begin
            g = sb.pop_front();
            chk("state", 16'(bus.state_out), 16'(g.st));
            chk("wen", 16'({bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.PCWrite}), 16'(g.we));
            chk("cpu_mio", 16'(bus.CPU_MIO), 16'(g.we[4] | g.we[3]));
            if (g.chk_alu) chk("alu", 16'(bus.ALU_Control), 16'(g.alu));
            if (g.chk_sig) chk("dpath", 16'({bus.RegDst, bus.DatatoReg, bus.ALUSrcA, bus.ALUSrcB,
                                              bus.PCSource, bus.IorD}), 16'(g.sig));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fun, input logic z, input int n,
                                input logic [29:0] st, input logic [29:0] we,
                                input logic [2:0] alu, input logic [9:0] sig);
        vec_t v;
        v.op = op; v.fun = fun; v.z = z; v.n = n;
        v.st = st; v.we = we; v.alu = alu; v.sig = sig;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        // R-type: IF, ID, REXE, RWB
        vecs.push_back(mk(6'b000000, 6'b100010, 1'b0, 4, {5'd0,5'd1,5'd6,5'd7,5'd0,5'd0}, {W_IF,W_0,W_0,W_RW,W_0,W_0}, 3'b110, SG_RWB));
        vecs.push_back(mk(6'b000000, 6'b100100, 1'b0, 4, {5'd0,5'd1,5'd6,5'd7,5'd0,5'd0}, {W_IF,W_0,W_0,W_RW,W_0,W_0}, 3'b000, SG_RWB));
        vecs.push_back(mk(6'b000000, 6'b100111, 1'b0, 4, {5'd0,5'd1,5'd6,5'd7,5'd0,5'd0}, {W_IF,W_0,W_0,W_RW,W_0,W_0}, 3'b100, SG_RWB));
        vecs.push_back(mk(6'b000000, 6'b000010, 1'b0, 4, {5'd0,5'd1,5'd6,5'd7,5'd0,5'd0}, {W_IF,W_0,W_0,W_RW,W_0,W_0}, 3'b101, SG_RWB));
        vecs.push_back(mk(6'b000000, 6'b101010, 1'b0, 4, {5'd0,5'd1,5'd6,5'd7,5'd0,5'd0}, {W_IF,W_0,W_0,W_RW,W_0,W_0}, 3'b111, SG_RWB));
        vecs.push_back(mk(6'b000000, 6'b111111, 1'b0, 4, {5'd0,5'd1,5'd6,5'd7,5'd0,5'd0}, {W_IF,W_0,W_0,W_RW,W_0,W_0}, 3'b010, SG_RWB));
        // I-type ALU: IF, ID, IEXE, IWB
        vecs.push_back(mk(6'b001010, 6'b000000, 1'b0, 4, {5'd0,5'd1,5'd12,5'd13,5'd0,5'd0}, {W_IF,W_0,W_0,W_RW,W_0,W_0}, 3'b111, SG_IWB));
        vecs.push_back(mk(6'b001101, 6'b100010, 1'b0, 4, {5'd0,5'd1,5'd12,5'd13,5'd0,5'd0}, {W_IF,W_0,W_0,W_RW,W_0,W_0}, 3'b001, SG_IWB));
        vecs.push_back(mk(6'b001110, 6'b000000, 1'b0, 4, {5'd0,5'd1,5'd12,5'd13,5'd0,5'd0}, {W_IF,W_0,W_0,W_RW,W_0,W_0}, 3'b011, SG_IWB));
        // loads and stores
        vecs.push_back(mk(6'b100011, 6'b000000, 1'b0, 5, {5'd0,5'd1,5'd2,5'd3,5'd4,5'd0}, {W_IF,W_0,W_0,W_MR,W_RW,W_0}, 3'b010, SG_LWB));
        vecs.push_back(mk(6'b101011, 6'b000000, 1'b0, 4, {5'd0,5'd1,5'd2,5'd5,5'd0,5'd0}, {W_IF,W_0,W_0,W_MW,W_0,W_0}, 3'b010, SG_MEM));
        // branches: PCWrite follows zero (beq) or its inverse (bne)
        vecs.push_back(mk(6'b000101, 6'b000000, 1'b0, 3, {5'd0,5'd1,5'd9,5'd0,5'd0,5'd0}, {W_IF,W_0,W_PC,W_0,W_0,W_0}, 3'b110, SG_BR));
        vecs.push_back(mk(6'b000101, 6'b000000, 1'b1, 3, {5'd0,5'd1,5'd9,5'd0,5'd0,5'd0}, {W_IF,W_0,W_0,W_0,W_0,W_0}, 3'b110, SG_BR));
        vecs.push_back(mk(6'b000100, 6'b000000, 1'b1, 3, {5'd0,5'd1,5'd8,5'd0,5'd0,5'd0}, {W_IF,W_0,W_PC,W_0,W_0,W_0}, 3'b110, SG_BR));
        vecs.push_back(mk(6'b000100, 6'b000000, 1'b0, 3, {5'd0,5'd1,5'd8,5'd0,5'd0,5'd0}, {W_IF,W_0,W_0,W_0,W_0,W_0}, 3'b110, SG_BR));
        // jumps and lui; Fun is ignored outside R-type
        vecs.push_back(mk(6'b000010, 6'b001000, 1'b0, 3, {5'd0,5'd1,5'd10,5'd0,5'd0,5'd0}, {W_IF,W_0,W_PC,W_0,W_0,W_0}, 3'b010, SG_J));
        vecs.push_back(mk(6'b000011, 6'b000000, 1'b0, 3, {5'd0,5'd1,5'd11,5'd0,5'd0,5'd0}, {W_IF,W_0,W_LINK,W_0,W_0,W_0}, 3'b010, SG_JAL));
        vecs.push_back(mk(6'b000000, 6'b001000, 1'b0, 3, {5'd0,5'd1,5'd15,5'd0,5'd0,5'd0}, {W_IF,W_0,W_PC,W_0,W_0,W_0}, 3'b010, SG_JR));
        vecs.push_back(mk(6'b000000, 6'b001001, 1'b0, 3, {5'd0,5'd1,5'd16,5'd0,5'd0,5'd0}, {W_IF,W_0,W_LINK,W_0,W_0,W_0}, 3'b010, SG_JALR));
        vecs.push_back(mk(6'b001111, 6'b000000, 1'b0, 3, {5'd0,5'd1,5'd14,5'd0,5'd0,5'd0}, {W_IF,W_0,W_RW,W_0,W_0,W_0}, 3'b010, SG_LUI));
        // unknown opcode executes as a NOP
        vecs.push_back(mk(6'b010000, 6'b000000, 1'b0, 2, {5'd0,5'd1,5'd0,5'd0,5'd0,5'd0}, {W_IF,W_0,W_0,W_0,W_0,W_0}, 3'b010, SG_ID));

        reset         = 1'b1;
        bus.OPcode    = 6'b000000;
        bus.Fun       = 6'b100010;
        bus.zero      = 1'b0;
        bus.MIO_ready = 1'b1;
        @(posedge clk);
        #1;
        // reset held: IF but every write enable forced low
        step(1'b1, 1'b1, 5'd0, W_0, 1'b0, 3'b010, 1'b1, SG_IF);
        step(1'b1, 1'b1, 5'd0, W_0, 1'b0, 3'b010, 1'b1, SG_IF);

        foreach (vecs[i]) begin
            bus.OPcode = vecs[i].op;
            bus.Fun    = vecs[i].fun;
            bus.zero   = vecs[i].z;
            for (int k = 0; k < vecs[i].n; k++)
                step(1'b0, 1'b1, vecs[i].st[k], vecs[i].we[k], k == 2, vecs[i].alu,
                     k == vecs[i].n - 1, vecs[i].sig);
        end

        // lw with a fetch stall and a two-cycle memory stall in MRD
        bus.OPcode = 6'b100011;
        bus.Fun    = 6'b000000;
        step(1'b0, 1'b0, 5'd0, W_MR, 1'b0, 3'b010, 1'b1, SG_IF);
        step(1'b0, 1'b1, 5'd0, W_IF, 1'b0, 3'b010, 1'b1, SG_IF);
        step(1'b0, 1'b1, 5'd1, W_0,  1'b0, 3'b010, 1'b1, SG_ID);
        step(1'b0, 1'b1, 5'd2, W_0,  1'b1, 3'b010, 1'b0, SG_IF);
        step(1'b0, 1'b0, 5'd3, W_MR, 1'b0, 3'b010, 1'b1, SG_MEM);
        step(1'b0, 1'b0, 5'd3, W_MR, 1'b0, 3'b010, 1'b1, SG_MEM);
        step(1'b0, 1'b1, 5'd3, W_MR, 1'b0, 3'b010, 1'b1, SG_MEM);
        step(1'b0, 1'b1, 5'd4, W_RW, 1'b0, 3'b010, 1'b1, SG_LWB);

        // sw stalled in MWR, then reset during the stall aborts the store
        bus.OPcode = 6'b101011;
        step(1'b0, 1'b1, 5'd0, W_IF, 1'b0, 3'b010, 1'b0, SG_IF);
        step(1'b0, 1'b1, 5'd1, W_0,  1'b0, 3'b010, 1'b0, SG_IF);
        step(1'b0, 1'b1, 5'd2, W_0,  1'b0, 3'b010, 1'b0, SG_IF);
        step(1'b0, 1'b0, 5'd5, W_MW, 1'b0, 3'b010, 1'b1, SG_MEM);
        step(1'b1, 1'b0, 5'd5, W_0,  1'b0, 3'b010, 1'b1, SG_MEM);
        step(1'b0, 1'b1, 5'd0, W_IF, 1'b0, 3'b010, 1'b1, SG_IF);

        // branch resolves combinationally on zero within the BNE cycle
        bus.OPcode = 6'b000101;
        bus.zero   = 1'b1;
        step(1'b0, 1'b1, 5'd1, W_0, 1'b0, 3'b010, 1'b0, SG_IF);
        #2;
        total++;
        if (bus.PCWrite !== 1'b0) begin
            bad++;
            $display("FAIL bne_z1_pcwrite cyc=%0d got=%b want=0", cyc, bus.PCWrite);
        end
        bus.zero = 1'b0;
        #1;
        total++;
        if (bus.PCWrite !== 1'b1) begin
            bad++;
            $display("FAIL bne_z0_pcwrite cyc=%0d got=%b want=1", cyc, bus.PCWrite);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
